matvec_result_drain: RTL and testbench

MATVEC_RESULT_DRAIN -- requirements
Module: matvec_result_drain

---
 rtl/matvec_result_drain.sv | 102 ++++++++++
 tb/tb_matvec_result_drain.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_result_drain.sv
// rtl/matvec_result_drain.sv - captures a matvec result vector on done rising edge and streams it word by word
module matvec_result_drain #(
    parameter int NUM_ROWS = 8,
    parameter int RES_W    = 24,
    localparam int IDX_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int CSUM_W  = RES_W + IDX_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             done,
    input  logic [NUM_ROWS-1:0][RES_W-1:0]   results,
    output logic [RES_W-1:0]                 out_data,
    output logic [IDX_W-1:0]                 out_idx,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy,
    output logic                             ovf,
    output logic [CSUM_W-1:0]                checksum,
    output logic                             checksum_valid
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                           state;
    logic                             done_q;
    logic [NUM_ROWS-1:0][RES_W-1:0]   row_buf;
    logic [IDX_W-1:0]                 idx;
    logic                             done_rise;
    logic                             xfer;
    logic                             at_last;

    assign done_rise = done && !done_q;
    assign at_last   = (idx == IDX_W'(NUM_ROWS - 1));
    assign xfer      = (state == STREAM) && out_ready;

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_last  = (state == STREAM) && at_last;
    assign out_idx   = idx;
    assign out_data  = row_buf[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            done_q         <= 1'b0;
            row_buf        <= '0;
            idx            <= '0;
            ovf            <= 1'b0;
            checksum       <= '0;
            checksum_valid <= 1'b0;
        end else begin
            done_q <= done;
            if (clr) begin
                state          <= IDLE;
                idx            <= '0;
                ovf            <= 1'b0;
                checksum       <= '0;
                checksum_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (done_rise) begin
                            row_buf        <= results;
                            idx            <= '0;
                            checksum       <= '0;
                            checksum_valid <= 1'b0;
                            state          <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (xfer && at_last) begin
                            // a new vector arriving on the final handshake chains straight on
                            if (done_rise) begin
                                row_buf        <= results;
                                idx            <= '0;
                                checksum       <= '0;
                                checksum_valid <= 1'b0;
                            end else begin
                                state          <= IDLE;
                                idx            <= '0;
                                checksum       <= checksum + CSUM_W'(row_buf[idx]);
                                checksum_valid <= 1'b1;
                            end
                        end else begin
                            if (xfer) begin
                                idx      <= idx + IDX_W'(1);
                                checksum <= checksum + CSUM_W'(row_buf[idx]);
                            end
                            if (done_rise) begin
                                ovf <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matvec_result_drain.sv
// tb/tb_matvec_result_drain.sv - scoreboard bench for matvec_result_drain
module tb_matvec_result_drain;

    typedef logic [7:0][23:0] vec_t;
    typedef struct {
        int          idx;
        logic [23:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, clr, done, out_ready;
    vec_t        results;
    logic [23:0] out_data;
    logic [2:0]  out_idx;
    logic        out_valid, out_last, busy, ovf, checksum_valid;
    logic [26:0] checksum;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;
    vec_t va, vb;

    matvec_result_drain dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .done           (done),
        .results        (results),
        .out_data       (out_data),
        .out_idx        (out_idx),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .ovf            (ovf),
        .checksum       (checksum),
        .checksum_valid (checksum_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] vsum(input vec_t v);
        logic [63:0] s = 0;
        for (int i = 0; i < 8; i++) s += 64'(v[i]);
        return s;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = 24'($urandom);
        return v;
    endfunction

    task automatic push_vec(input vec_t v);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.idx  = i;
            e.data = v[i];
            sb.push_back(e);
        end
    endtask

    // drive a one-cycle done pulse with vector v; caller is at a negedge
    task automatic capture(input vec_t v);
        results = v;
        done    = 1'b1;
        push_vec(v);
        @(negedge clk);
        done = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,...
    task automatic drain(input int mode, input int inj_idx, input bit inj_push,
                         input vec_t inj_vec, input int max_words, output int cycles);
        int          k = 0;
        int          words = 0;
        bit          stalled = 0;
        bit          injected = 0;
        bit          drop_done = 0;
        logic [23:0] hd = '0;
        logic [2:0]  hi = '0;
        exp_t        e;
        cycles = 0;
        while (sb.size() > 0 && words < max_words && cycles < 200) begin
            if (drop_done) begin
                done      = 1'b0;
                drop_done = 0;
            end
            chk("stream_valid", 64'(out_valid), 64'd1);
            if (stalled) begin
                chk("stall_data", 64'(out_data), 64'(hd));
                chk("stall_idx", 64'(out_idx), 64'(hi));
            end
            out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
            k++;
            if (!injected && inj_idx >= 0 && out_valid && int'(out_idx) == inj_idx) begin
                results   = inj_vec;
                done      = 1'b1;
                injected  = 1;
                drop_done = 1;
                if (inj_push) push_vec(inj_vec);
            end
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                chk("word_data", 64'(out_data), 64'(e.data));
                chk("word_idx", 64'(out_idx), 64'(e.idx));
                chk("word_last", 64'(out_last), 64'(e.idx == 7));
                words++;
                stalled = 0;
            end else if (out_valid) begin
                stalled = 1;
                hd = out_data;
                hi = out_idx;
            end
            @(negedge clk);
            cycles++;
        end
        if (drop_done) done = 1'b0;
        chk("drain_complete", 64'(sb.size() == 0 || words == max_words), 64'd1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_idx"}, 64'(out_idx), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_csum"}, 64'(checksum), 64'd0);
        chk({tag, "_csum_valid"}, 64'(checksum_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; done = 1'b0; out_ready = 1'b0; results = '0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // incrementing vector, full throughput
        for (int i = 0; i < 8; i++) va[i] = 24'(i + 1);
        capture(va);
        drain(0, -1, 0, '0, 100, cyc);
        chk("inc_throughput", 64'(cyc), 64'd8);
        chk("inc_csum", 64'(checksum), 64'd36);
        chk("inc_csum_valid", 64'(checksum_valid), 64'd1);
        chk("inc_end_valid", 64'(out_valid), 64'd0);
        chk("inc_end_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        chk("csum_hold", 64'(checksum), 64'd36);

        // all-ones words must not truncate the checksum
        for (int i = 0; i < 8; i++) va[i] = 24'hFFFFFF;
        capture(va);
        chk("new_capture_clears_csum_valid", 64'(checksum_valid), 64'd0);
        drain(0, -1, 0, '0, 100, cyc);
        chk("max_csum", 64'(checksum), 64'h7FFFFF8);
        chk("max_csum_valid", 64'(checksum_valid), 64'd1);

        // back-pressure pattern
        va = rand_vec();
        capture(va);
        drain(1, -1, 0, '0, 100, cyc);
        chk("stall_csum", 64'(checksum), vsum(va));
        chk("stall_end_valid", 64'(out_valid), 64'd0);

        // done rising edge mid-stream is dropped and flagged
        va = rand_vec();
        vb = rand_vec();
        capture(va);
        drain(0, 3, 0, vb, 100, cyc);
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("ovf_csum", 64'(checksum), vsum(va));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_ovf", 64'(ovf), 64'd0);
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_csum", 64'(checksum), 64'd0);
        chk("clr_csum_valid", 64'(checksum_valid), 64'd0);

        // clr mid-stream aborts the remaining words
        va = rand_vec();
        capture(va);
        drain(0, -1, 0, '0, 2, cyc);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        sb.delete();
        chk("clr_mid_valid", 64'(out_valid), 64'd0);
        chk("clr_mid_csum", 64'(checksum), 64'd0);

        // done rising edge on last-word transfer chains a second vector
        va = rand_vec();
        vb = rand_vec();
        capture(va);
        drain(0, 7, 1, vb, 100, cyc);
        chk("b2b_cycles", 64'(cyc), 64'd16);
        chk("b2b_ovf", 64'(ovf), 64'd0);
        chk("b2b_csum", 64'(checksum), vsum(vb));
        chk("b2b_csum_valid", 64'(checksum_valid), 64'd1);

        // reset mid-stream, then done held high across release
        va = rand_vec();
        capture(va);
        drain(0, -1, 0, '0, 4, cyc);
        chk("pre_reset_idx", 64'(out_idx), 64'd4);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("async_reset");
        sb.delete();
        vb = rand_vec();
        results = vb;
        done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        push_vec(vb);
        @(negedge clk);
        drain(0, -1, 0, '0, 100, cyc);
        chk("held_done_words", 64'(cyc), 64'd8);
        for (int i = 0; i < 10; i++) begin
            chk("held_done_no_recapture", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        done = 1'b0;
        chk("held_done_ovf", 64'(ovf), 64'd0);
        chk("held_done_csum", 64'(checksum), vsum(vb));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
